spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI target (slave) that terminates the team's 8-bit SPI master link.
- Protocol:
  - CS active low; SCLK idles high.
  - Master drives MOSI on SCLK falling edges and samples MISO on SCLK rising edges, MSB first.
- The slave oversamples SCLK, CS and MOSI in its own clk_i domain, assembles received words, and shifts out a preloaded response word.
- Parallel side offers a valid/ready TX buffer and a pulsed RX output for the local register/bus logic.

Parameters:
- DATA_WIDTH, 8, bits per frame (one word per CS assertion).
- SYNC_STAGES, 2, flip-flop synchronizer depth on sclk_i/cs_i/mosi_i (minimum 2).
- IDLE_TX, 8'hFF, word shifted out when no TX word is buffered at frame start (width DATA_WIDTH).

Ports:
- clk_i  input  1  system clock; must be >= 4x SCLK frequency.
- aresetn_i  input  1  reset, asynchronous, active-low.
- sclk_i  input  1  SPI clock from master, idle high.
- cs_i  input  1  chip select, active low.
- mosi_i  input  1  serial data from master.
- miso_o  output  1  serial data to master.
- miso_oe_o  output  1  MISO output enable (1 while frame active).
- tx_data_i  input  DATA_WIDTH  response word.
- tx_valid_i  input  1  tx_data_i valid.
- tx_ready_o  output  1  TX holding buffer empty.
- rx_data_o  output  DATA_WIDTH  last complete received word.
- rx_valid_o  output  1  one-cycle pulse: rx_data_o updated.
- tx_underrun_o  output  1  one-cycle pulse: frame started with empty TX buffer.
- frame_err_o  output  1  one-cycle pulse: CS released before DATA_WIDTH bits.
- busy_o  output  1  frame in progress.

Behaviour:
- Reset (async, aresetn_i low):
  - All outputs and state clear: miso_o=0, miso_oe_o=0, tx_ready_o=1, rx_data_o=0, all pulses 0, busy_o=0.
  - State=IDLE; TX buffer empty.
  - Synchronizers preset to the idle line levels: sclk=1, cs=1, mosi=0.
- Sync/edges:
  - sclk_i, cs_i and mosi_i each pass through SYNC_STAGES flops.
  - Edges are detected on the synced sclk and cs by comparing with a one-flop-delayed copy.
  - Synced mosi is sampled in the same cycle as the synced rise, so the three stay aligned.
- TX buffer:
  - Single holding register; tx_ready_o = buffer empty.
  - Write on tx_valid_i & tx_ready_o; tx_ready_o drops the next cycle.
  - Writes are accepted in any state; the buffer is consumed only at frame start.
- FSM IDLE -> ACTIVE -> DONE:
  - IDLE, on synced cs falling edge:
    - Load the shift register from the buffer (buffer becomes empty) or from IDLE_TX; IDLE_TX also pulses tx_underrun_o.
    - bit_cnt=0; miso_o=shift[MSB]; miso_oe_o=1; busy_o=1.
    - Go to ACTIVE.
  - ACTIVE, synced sclk rising edge:
    - rx_shift = {rx_shift[W-2:0], mosi_sync}; bit_cnt++.
    - On the DATA_WIDTH-th rise: rx_data_o <= assembled word, rx_valid_o=1 the following cycle, go to DONE.
  - ACTIVE, synced sclk falling edge:
    - If bit_cnt==0: ignore (MSB already presented; covers the master's leading fall).
    - Else: tx shift left, miso_o <= next bit.
  - ACTIVE, cs rises before the word is complete:
    - Discard the partial word; no rx_valid_o; frame_err_o pulses one cycle.
    - miso_oe_o=0, miso_o=0, busy_o=0; go to IDLE.
  - DONE:
    - Ignore further SCLK edges; miso_o holds the last bit.
    - On cs rise: miso_oe_o=0, miso_o=0, busy_o=0, go to IDLE with no error.
- Simultaneous events:
  - cs rise and the final sclk rise synced in the same cycle: word counts as complete (rx_valid_o pulses, no frame_err_o).
  - TX write in the same cycle as frame-start load: the load uses IDLE_TX (underrun pulse), and the new word stays buffered for the next frame.
- rx_data_o holds its value until the next complete frame. There is no backpressure; the consumer must take the word within one frame time.
- Latency: rx_valid_o is asserted SYNC_STAGES+2 clk_i cycles after the final physical SCLK rise.

Test Plan:
- Write tx_data_i=0xA5 (ready drops); master frame sending MOSI 0x3C at SCLK=clk_i/8 -> MISO bits 1,0,1,0,0,1,0,1 sampled on rises; rx_data_o=0x3C with a single rx_valid_o pulse; tx_ready_o=1 after frame start.
- Frame with TX buffer empty -> tx_underrun_o pulses once at CS fall; master reads 0xFF.
- Back-to-back frames with TX words 0x12, 0x34 and MOSI 0x81, 0x7E -> two rx_valid_o pulses with 0x81 then 0x7E; master reads 0x12 then 0x34.
- CS released after 5 SCLK rises -> frame_err_o pulses once, no rx_valid_o, rx_data_o unchanged; the next full frame receives correctly.
- Extra 3 SCLK pulses after 8 bits before CS rise -> ignored; exactly one rx_valid_o pulse; miso_o stable.
- aresetn_i low mid-frame (bit 4) -> all outputs immediately at reset values; after release, the frame is not resumed and the next CS fall starts a clean frame.

Source files
------------

// File: rtl/spi_slave_if.sv
// ---------------------------------------------------------------------------
// spi_slave_if
//   Parallel-side bundle between spi_slave and the local register/bus logic.
//
//   Signals (directions as seen from the SPI slave):
//     tx_data_i     in   response word for the next frame
//     tx_valid_i    in   tx_data_i valid
//     tx_ready_o    out  TX holding buffer empty
//     rx_data_o     out  last complete received word
//     rx_valid_o    out  one-cycle pulse: rx_data_o updated
//     tx_underrun_o out  one-cycle pulse: frame started with empty TX buffer
//     frame_err_o   out  one-cycle pulse: CS released before a full word
//     busy_o        out  frame in progress
//
//   Handshake: a TX word transfers on any rising clk edge where
//   tx_valid_i && tx_ready_o. The producer holds tx_data_i stable while
//   tx_valid_i is high and not yet accepted; ready never depends on valid.
//   RX has no backpressure: rx_data_o is valid in the cycle rx_valid_o is
//   high and stays put until the next complete frame.
// ---------------------------------------------------------------------------
interface spi_slave_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data_i;
  logic                  tx_valid_i;
  logic                  tx_ready_o;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  rx_valid_o;
  logic                  tx_underrun_o;
  logic                  frame_err_o;
  logic                  busy_o;

  modport slave (
    input  tx_data_i, tx_valid_i,
    output tx_ready_o, rx_data_o, rx_valid_o, tx_underrun_o, frame_err_o, busy_o
  );

  modport master (
    output tx_data_i, tx_valid_i,
    input  tx_ready_o, rx_data_o, rx_valid_o, tx_underrun_o, frame_err_o, busy_o
  );
endinterface

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
//   SPI target for the 8-bit SPI master link (CS active low, SCLK idles high,
//   master drives MOSI on falling edges and samples MISO on rising edges,
//   MSB first). SCLK/CS/MOSI are oversampled in the clk_i domain, which must
//   run at least 4x SCLK.
//
//   Ports:
//     clk_i        system clock
//     aresetn_i    asynchronous active-low reset
//     sclk_i       SPI clock from master
//     cs_i         chip select, active low
//     mosi_i       serial data from master
//     miso_o       serial data to master
//     miso_oe_o    MISO output enable, high while a frame is active
//     dbg_state_o  current FSM state (0 IDLE, 1 ACTIVE, 2 DONE)
//     bus          parallel TX/RX side, see spi_slave_if
// ---------------------------------------------------------------------------
module spi_slave #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,  // must be >= 2
  parameter logic [DATA_WIDTH-1:0] IDLE_TX     = {DATA_WIDTH{1'b1}}
) (
  input  logic        clk_i,
  input  logic        aresetn_i,
  input  logic        sclk_i,
  input  logic        cs_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_oe_o,
  output logic [1:0]  dbg_state_o,
  spi_slave_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Synchronizers, preset to the idle line levels so reset release does not
  // look like an edge on a quiet bus.
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  logic w_sclk_s, w_cs_s, w_mosi_s;
  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_sclk_sync <= '1;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b1;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  // MOSI goes through the same depth as SCLK, so at a synced rise it holds
  // the bit the master set up before that physical rise.
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
  assign w_cs_fall   = ~w_cs_s   &  r_cs_d;
  assign w_cs_rise   =  w_cs_s   & ~r_cs_d;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_tx_buf;
  logic                  r_tx_full;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_miso;
  logic                  r_miso_oe;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_pend;
  logic                  r_rx_valid;
  logic                  r_underrun;
  logic                  r_frame_err;

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_state     <= ST_IDLE;
      r_tx_buf    <= '0;
      r_tx_full   <= 1'b0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_bit_cnt   <= '0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_busy      <= 1'b0;
      r_rx_data   <= '0;
      r_rx_pend   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      // rx_data_o is updated one cycle before rx_valid_o is raised.
      r_rx_valid  <= r_rx_pend;
      r_rx_pend   <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;

      // Accept only into an empty buffer, so this never collides with the
      // frame-start consume below (that path requires a full buffer). A word
      // written in the load cycle therefore waits for the next frame.
      if (bus.tx_valid_i && !r_tx_full) begin
        r_tx_buf  <= bus.tx_data_i;
        r_tx_full <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            if (r_tx_full) begin
              r_tx_shift <= r_tx_buf;
              r_miso     <= r_tx_buf[DATA_WIDTH-1];
              r_tx_full  <= 1'b0;
            end else begin
              r_tx_shift <= IDLE_TX;
              r_miso     <= IDLE_TX[DATA_WIDTH-1];
              r_underrun <= 1'b1;
            end
            r_bit_cnt <= '0;
            r_miso_oe <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          if (w_sclk_rise) begin
            r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi_s};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == LAST_BIT) begin
              r_rx_data <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi_s};
              r_rx_pend <= 1'b1;
              // CS rising together with the final rise still completes.
              if (w_cs_rise) begin
                r_miso_oe <= 1'b0;
                r_miso    <= 1'b0;
                r_busy    <= 1'b0;
                r_state   <= ST_IDLE;
              end else begin
                r_state   <= ST_DONE;
              end
            end else if (w_cs_rise) begin
              r_frame_err <= 1'b1;
              r_miso_oe   <= 1'b0;
              r_miso      <= 1'b0;
              r_busy      <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end else if (w_cs_rise) begin
            r_frame_err <= 1'b1;
            r_miso_oe   <= 1'b0;
            r_miso      <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
            // The master's leading fall (count 0) is skipped: the MSB has
            // been on the line since CS fell.
            r_tx_shift <= r_tx_shift << 1;
            r_miso     <= r_tx_shift[DATA_WIDTH-2];
          end
        end

        ST_DONE: begin
          if (w_cs_rise) begin
            r_miso_oe <= 1'b0;
            r_miso    <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign miso_o            = r_miso;
  assign miso_oe_o         = r_miso_oe;
  assign dbg_state_o       = r_state;
  assign bus.tx_ready_o    = ~r_tx_full;
  assign bus.rx_data_o     = r_rx_data;
  assign bus.rx_valid_o    = r_rx_valid;
  assign bus.tx_underrun_o = r_underrun;
  assign bus.frame_err_o   = r_frame_err;
  assign bus.busy_o        = r_busy;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int HALF = 4;  // SCLK half period in clk cycles (SCLK = clk/8)

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic sclk = 1'b1;
  logic cs   = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe;
  logic [1:0] dbg_state;

  spi_slave_if #(.DATA_WIDTH(DW)) bus ();

  spi_slave #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SYNC),
    .IDLE_TX    (8'hFF)
  ) dut (
    .clk_i      (clk),
    .aresetn_i  (aresetn),
    .sclk_i     (sclk),
    .cs_i       (cs),
    .mosi_i     (mosi),
    .miso_o     (miso),
    .miso_oe_o  (miso_oe),
    .dbg_state_o(dbg_state),
    .bus        (bus.slave)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];        // words that must appear on rx_valid_o
  logic          model_full = 1'b0;
  logic [DW-1:0] model_word = '0;
  logic [DW-1:0] last_good  = '0;  // rx_data_o must hold this between frames
  int            last_rise_cyc = 0;

  int n_rx  = 0;
  int n_err = 0;
  int n_unr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every rx_valid_o pulse is checked against the expected
  // queue and against the fixed latency from the final physical SCLK rise.
  always @(negedge clk) begin
    if (aresetn) begin
      if (bus.rx_valid_o) begin
        n_rx++;
        check("rx_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check("rx_data", 32'(bus.rx_data_o), 32'(exp_q.pop_front()));
          check("rx_latency", 32'(cyc - last_rise_cyc), 32'(SYNC + 2));
        end
      end
      if (bus.frame_err_o)   n_err++;
      if (bus.tx_underrun_o) n_unr++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input logic [DW-1:0] w);
    check("tx_ready_pre", 32'(bus.tx_ready_o), 32'(!model_full));
    bus.tx_data_i  = w;
    bus.tx_valid_i = 1'b1;
    tick(1);
    bus.tx_valid_i = 1'b0;
    check("tx_ready_post", 32'(bus.tx_ready_o), 32'd0);
    model_full = 1'b1;
    model_word = w;
  endtask

  // One master frame. nbits = SCLK rises before CS release (< DW aborts),
  // extra = surplus pulses after a full word, cs_last = CS rises together
  // with the final rise, wstart = TX write lands in the frame-start cycle.
  task automatic do_frame(input logic [DW-1:0] mosi_w, input int nbits, input int extra,
                          input bit cs_last, input bit wstart, input logic [DW-1:0] late_w,
                          output logic [DW-1:0] miso_w);
    logic [DW-1:0] exp_tx;
    bit            exp_unr;
    int            rx0, err0, unr0;
    exp_tx  = model_full ? model_word : 8'hFF;
    exp_unr = !model_full;
    model_full = 1'b0;
    if (wstart) begin
      model_full = 1'b1;
      model_word = late_w;
    end
    if (nbits == DW) exp_q.push_back(mosi_w);
    rx0 = n_rx; err0 = n_err; unr0 = n_unr;
    miso_w = '0;

    cs = 1'b0;
    if (wstart) begin
      tick(2);
      bus.tx_data_i  = late_w;
      bus.tx_valid_i = 1'b1;
      tick(1);
      bus.tx_valid_i = 1'b0;
      tick(HALF - 3);
    end else begin
      tick(HALF);
    end
    check("busy_in_frame", 32'(bus.busy_o), 32'd1);
    check("oe_in_frame", 32'(miso_oe), 32'd1);

    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = mosi_w[DW-1-i];
      tick(HALF);
      miso_w[DW-1-i] = miso;
      if (i == nbits - 1 && cs_last) cs = 1'b1;
      sclk = 1'b1;
      if (i == DW - 1) last_rise_cyc = cyc;
      tick(HALF);
    end
    for (int e = 0; e < extra; e++) begin
      sclk = 1'b0;
      mosi = 1'($urandom_range(0, 1));
      tick(HALF);
      check("miso_hold", 32'(miso), 32'(exp_tx[0]));
      sclk = 1'b1;
      tick(HALF);
    end
    if (!cs_last) cs = 1'b1;
    tick(10);

    check("miso_bits", 32'(miso_w >> (DW - nbits)), 32'(exp_tx >> (DW - nbits)));
    check("rx_pulses", 32'(n_rx - rx0), 32'(nbits == DW));
    check("err_pulses", 32'(n_err - err0), 32'(nbits != DW));
    check("unr_pulses", 32'(n_unr - unr0), 32'(exp_unr));
    if (nbits == DW) last_good = mosi_w;
    check("rx_data_hold", 32'(bus.rx_data_o), 32'(last_good));
    check("busy_after", 32'(bus.busy_o), 32'd0);
    check("oe_after", 32'(miso_oe), 32'd0);
    check("miso_after", 32'(miso), 32'd0);
    check("tx_ready_after", 32'(bus.tx_ready_o), 32'(!model_full));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] mw;
    bus.tx_data_i  = '0;
    bus.tx_valid_i = 1'b0;

    #12;
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_oe", 32'(miso_oe), 32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready_o), 32'd1);
    check("rst_rx_data", 32'(bus.rx_data_o), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid_o), 32'd0);
    check("rst_underrun", 32'(bus.tx_underrun_o), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    tick(2);
    aresetn = 1'b1;
    tick(5);

    // Preloaded word, MOSI 0x3C.
    tx_write(8'hA5);
    do_frame(8'h3C, DW, 0, 1'b0, 1'b0, 8'h00, mw);
    check("lit_miso_a5", 32'(mw), 32'hA5);
    check("lit_rx_3c", 32'(bus.rx_data_o), 32'h3C);

    // Empty buffer -> IDLE_TX and underrun.
    do_frame(8'h55, DW, 0, 1'b0, 1'b0, 8'h00, mw);
    check("lit_miso_ff", 32'(mw), 32'hFF);

    // Back-to-back.
    tx_write(8'h12);
    do_frame(8'h81, DW, 0, 1'b0, 1'b0, 8'h00, mw);
    check("lit_miso_12", 32'(mw), 32'h12);
    tx_write(8'h34);
    do_frame(8'h7E, DW, 0, 1'b0, 1'b0, 8'h00, mw);
    check("lit_miso_34", 32'(mw), 32'h34);
    check("lit_rx_7e", 32'(bus.rx_data_o), 32'h7E);

    // Aborted after 5 rises, then a clean frame.
    do_frame(8'hC3, 5, 0, 1'b0, 1'b0, 8'h00, mw);
    check("lit_rx_kept", 32'(bus.rx_data_o), 32'h7E);
    do_frame(8'h96, DW, 0, 1'b0, 1'b0, 8'h00, mw);

    // Extra SCLK pulses after a full word.
    tx_write(8'h3B);
    do_frame(8'h5A, DW, 3, 1'b0, 1'b0, 8'h00, mw);

    // TX write in the frame-start cycle: this frame underruns, next gets it.
    do_frame(8'h11, DW, 0, 1'b0, 1'b1, 8'hBE, mw);
    check("lit_miso_wstart", 32'(mw), 32'hFF);
    do_frame(8'h22, DW, 0, 1'b0, 1'b0, 8'h00, mw);
    check("lit_miso_be", 32'(mw), 32'hBE);

    // CS rise together with the final SCLK rise.
    do_frame(8'hE7, DW, 0, 1'b1, 1'b0, 8'h00, mw);

    // Reset in the middle of a frame.
    tx_write(8'h77);
    cs = 1'b0;
    tick(HALF);
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b0;
      mosi = 1'($urandom_range(0, 1));
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
    end
    sclk = 1'b0;
    tick(2);
    aresetn = 1'b0;
    #2;
    check("mid_rst_miso", 32'(miso), 32'd0);
    check("mid_rst_oe", 32'(miso_oe), 32'd0);
    check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    check("mid_rst_tx_ready", 32'(bus.tx_ready_o), 32'd1);
    check("mid_rst_rx_data", 32'(bus.rx_data_o), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    model_full = 1'b0;
    last_good  = '0;
    exp_q.delete();
    cs   = 1'b1;
    sclk = 1'b1;
    tick(4);
    aresetn = 1'b1;
    begin
      int rx0, err0;
      rx0 = n_rx; err0 = n_err;
      tick(12);
      check("post_rst_busy", 32'(bus.busy_o), 32'd0);
      check("post_rst_state", 32'(dbg_state), 32'd0);
      check("post_rst_no_rx", 32'(n_rx - rx0), 32'd0);
      check("post_rst_no_err", 32'(n_err - err0), 32'd0);
    end
    tx_write(8'hC9);
    do_frame(8'h69, DW, 0, 1'b0, 1'b0, 8'h00, mw);
    check("lit_miso_c9", 32'(mw), 32'hC9);

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      int  r, nb, ex;
      bit  csl, ws;
      r   = $urandom_range(0, 9);
      nb  = (r < 2) ? $urandom_range(1, DW - 1) : DW;
      ex  = (nb == DW && r == 2) ? $urandom_range(1, 3) : 0;
      csl = (nb == DW && r == 3);
      if (!model_full && r != 4 && $urandom_range(0, 1) == 1) tx_write(8'($urandom));
      ws  = (r == 4) && !model_full;
      do_frame(8'($urandom), nb, ex, csl, ws, 8'($urandom), mw);
    end

    tick(10);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
